// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: operand/result handshake bundle for wallace_mult_pipe
//   in_valid/in_ready, in_a, in_b, in_signed, in_tag : operand transaction
//   out_valid/out_ready, out_prod, out_tag             : result transaction
//   master = producer/consumer side, slave = multiplier side
interface wallace_mult_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_signed;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic [TAG_W-1:0]   out_tag;
    modport master (
        output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );
    modport slave (
        input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: 3-stage pipelined Wallace-tree multiplier, signed/unsigned per transaction
//   clk, rst : clock, synchronous active-high reset
//   bus      : wallace_mult_pipe_if.slave (operands + tag in, product + tag out, valid/ready both sides)
module wallace_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    wallace_mult_pipe_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int ROWS = WIDTH + 1;
    // 3:2 reduction levels needed to bring 33 rows (WIDTH=32) down to 2
    localparam int LEVELS = 8;
    logic v1, v2, v3, advance;
    logic [WIDTH-1:0] a1, b1;
    logic sg1;
    logic [TAG_W-1:0] t1, t2, tag;
    logic [PW-1:0] row_s, row_c, sum2, car2, prod;
    assign advance = !v3 || bus.out_ready;
    assign bus.in_ready = advance;
    assign bus.out_valid = v3;
    assign bus.out_prod = prod;
    assign bus.out_tag = tag;
    // Baugh-Wooley: in signed mode invert partial products touching exactly one sign bit,
    // and add constant ones at columns WIDTH and 2*WIDTH-1 (extra row).
    // Rows are then reduced in groups of three with full adders until two remain.
    always_comb begin
        logic [PW-1:0] r [ROWS];
        logic [PW-1:0] s, c;
        int n, g;
        s = '0;
        c = '0;
        for (int i = 0; i < ROWS; i++) r[i] = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                r[i][i+j] = (a1[j] & b1[i]) ^ (sg1 & ((i == WIDTH-1) != (j == WIDTH-1)));
        r[WIDTH][WIDTH] = sg1;
        r[WIDTH][PW-1] = sg1;
        n = ROWS;
        for (int l = 0; l < LEVELS; l++) begin
            g = n / 3;
            for (int k = 0; k < ROWS / 3; k++)
                if (k < g) begin
                    s = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
                    c = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) | (r[3*k+1] & r[3*k+2])) << 1;
                    r[2*k] = s;
                    r[2*k+1] = c;
                end
            for (int m = 0; m < ROWS; m++)
                if (m < n - 3*g) r[2*g+m] = r[3*g+m];
            n = n - g;
        end
        row_s = r[0];
        row_c = r[1];
    end
    // Global enable: every stage shifts together or holds together; data regs load only with valid
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            prod <= '0;
            tag <= '0;
        end else if (advance) begin
            v1 <= bus.in_valid;
            v2 <= v1;
            v3 <= v2;
            if (bus.in_valid) begin
                a1 <= bus.in_a;
                b1 <= bus.in_b;
                sg1 <= bus.in_signed;
                t1 <= bus.in_tag;
            end
            if (v1) begin
                sum2 <= row_s;
                car2 <= row_c;
                t2 <= t1;
            end
            if (v2) begin
                prod <= sum2 + car2;
                tag <= t2;
            end
        end
    end
endmodule
